sim_run_ctrl: RTL and testbench
===============================

// Module: sim_run_ctrl
// PURPOSE
//  Synthesizable run controller for CPU simulation and FPGA bring-up.
//  - Sequences the core's reset and counts cycles and retired instructions.
//  - Detects end of test from a tohost store, a cycle timeout or a retire stall (hang).
//  - Drives the reset of cpu_top and reports a sticky verdict to the bench.
//  - Generalises the fixed clock/reset/run-for-N-ns harness to a parametrised block with multiple retire lanes.
// PARAMETERS
//  XLEN           32          data/address width of store and retire ports
//  NUM_RET        1           retire lanes per cycle (1..4)
//  CNT_W          32          width of cycle_count/instret_count
//  RESET_CYCLES   30          cycles core_reset is held after reset drops (>=1)
//  TIMEOUT_CYCLES 1000        RUN cycles before TIMEOUT; 0 = disabled
//  STALL_LIMIT    256         consecutive no-retire cycles before HANG; 0 = disabled
//  TOHOST_ADDR    32'h0000_1000  end-of-test store address
//  HALT_ON_DONE   1           1 = reassert core_reset in DONE
// PORTS
//  clk            in   1        single clock
//  reset          in   1        synchronous, active-high
//  ret_valid      in   NUM_RET  per-lane instruction retire strobe
//  st_valid       in   1        data-memory store strobe from core
//  st_addr        in   XLEN     store address
//  st_data        in   XLEN     store data
//  core_reset     out  1        active-high reset to cpu_top
//  running        out  1        state==RUN
//  done           out  1        sticky end-of-test flag
//  status         out  3        verdict: NONE/PASS/FAIL/TIMEOUT/HANG
//  fail_code      out  XLEN     st_data>>1 on FAIL, else 0
//  cycle_count    out  CNT_W    RUN cycles elapsed, incl. terminating cycle
//  instret_count  out  CNT_W    retired instructions, sum of ret_valid bits
// BEHAVIOUR
//  Reset:
//   - state=HOLD; core_reset=1, running=0, done=0, status=NONE.
//   - fail_code=0, both counters=0, hold/idle counters=0.
//   - reset sampled high at any time, including mid-RUN or in DONE, gives this state at the next edge.
//  HOLD:
//   - hold_cnt increments per cycle.
//   - At hold_cnt==RESET_CYCLES-1 go to RUN.
//   - core_reset falls exactly RESET_CYCLES edges after the first edge sampling reset=0.
//  RUN, all registered, results visible 1 cycle after the event:
//   - cycle_count += 1.
//   - instret_count += popcount(ret_valid).
//   - Both counters saturate at all-ones and never wrap.
//   - idle_cnt clears on any ret_valid bit, else increments.
//   - tohost: st_valid && st_addr==TOHOST_ADDR && st_data[0]==1.
//     - st_data==1 -> PASS.
//     - Otherwise -> FAIL, fail_code=st_data>>1.
//     - tohost stores with st_data[0]==0 are ignored.
//   - HANG when STALL_LIMIT!=0 and idle_cnt reaches STALL_LIMIT
//     (STALL_LIMIT consecutive idle cycles).
//   - TIMEOUT when TIMEOUT_CYCLES!=0 and the updated cycle_count==TIMEOUT_CYCLES.
//   - Simultaneous terminations: priority tohost > HANG > TIMEOUT.
//   - Retires in the terminating cycle are counted.
//   - Any termination -> DONE with done=1 and status set.
//  DONE:
//   - Counters, status and fail_code frozen; sticky until reset.
//   - Further stores and retires are ignored.
//   - core_reset = HALT_ON_DONE.
//  status is never NONE while done=1.
// STRUCTURE
//  - Package sim_ctrl_pkg:
//    - status codes NONE=0, PASS=1, FAIL=2, TIMEOUT=3, HANG=4.
//    - FSM state constants HOLD/RUN/DONE.
//  - One sub-module sat_counter #(W) with ports clk, reset, clr, inc[W-1:0], q.
//    - Adds inc with saturation.
//    - Instantiated for cycle_count and instret_count.
//  - Popcount of ret_valid is inline combinational logic.
// TESTING
//  - Defaults, reset high 3 cycles then low -> core_reset low exactly 30 edges later, running=1, counters 0.
//  - 1 retire/cycle, store 0x1000<=1 in 100th RUN cycle -> done=1, status=PASS, cycle_count=100, instret_count=100.
//  - Store 0x1000<=0xB -> status=FAIL, fail_code=5; later stores do not change fail_code.
//  - STALL_LIMIT=64, no retires after run start -> HANG at cycle_count=64, core_reset=1 next cycle.
//  - NUM_RET=2, both lanes valid each cycle, TIMEOUT_CYCLES=500 -> TIMEOUT, cycle_count=500, instret_count=1000.
//  - Tohost PASS in the same cycle as the timeout -> PASS.
//  - Reset at cycle 50 of RUN -> HOLD, all outputs at reset values.
//  - CNT_W=4, 20 RUN cycles -> cycle_count holds at 15.

Source files
------------

// File: rtl/sim_ctrl_pkg.sv
// Shared status codes and FSM state encoding for the simulation run controller.
package sim_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_NONE    = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_HANG    = 3'd4
  } status_e;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Accumulating counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] inc,
  output logic [W-1:0] q
);

  logic [W:0] sum;

  assign sum = {1'b0, q} + {1'b0, inc};

  always_ff @(posedge clk) begin
    if (reset || clr) q <= '0;
    else if (sum[W])  q <= '1;
    else              q <= sum[W-1:0];
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: holds the core in reset, counts cycles/retires, and latches
// a sticky end-of-test verdict from tohost, a cycle timeout or a retire stall.
//
// state | meaning
// HOLD  | core_reset asserted for RESET_CYCLES cycles after reset drops
// RUN   | core running, counters active, end-of-test detection armed
// DONE  | verdict latched, everything frozen until reset
module sim_run_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int               XLEN           = 32,
  parameter int               NUM_RET        = 1,
  parameter int               CNT_W          = 32,
  parameter int               RESET_CYCLES   = 30,
  parameter int               TIMEOUT_CYCLES = 1000,
  parameter int               STALL_LIMIT    = 256,
  parameter logic [XLEN-1:0]  TOHOST_ADDR    = 'h0000_1000,
  parameter bit               HALT_ON_DONE   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_RET-1:0] ret_valid,
  input  logic               st_valid,
  input  logic [XLEN-1:0]    st_addr,
  input  logic [XLEN-1:0]    st_data,
  output logic               core_reset,
  output logic               running,
  output logic               done,
  output logic [2:0]         status,
  output logic [XLEN-1:0]    fail_code,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   instret_count
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int IDLE_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [IDLE_W-1:0] STALL_LIM_W = IDLE_W'(STALL_LIMIT);
  localparam logic [63:0]       TIMEOUT_W   = 64'(TIMEOUT_CYCLES);

  state_e             state, state_nxt;
  status_e            status_q;
  logic [XLEN-1:0]    fail_q;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [IDLE_W-1:0]  idle_cnt, idle_nxt;
  logic [CNT_W-1:0]   ret_pop, cyc_inc, ret_inc, cyc_nxt;
  logic               tohost_hit, hang_hit, timeout_hit, term;

  always_comb begin
    ret_pop = '0;
    for (int i = 0; i < NUM_RET; i++) ret_pop = ret_pop + CNT_W'(ret_valid[i]);
  end

  // Timeout compares against the post-increment count so the terminating
  // cycle itself is included; widened so a small CNT_W never aliases.
  always_comb begin
    idle_nxt    = (|ret_valid) ? '0 : idle_cnt + IDLE_W'(1);
    cyc_nxt     = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
    tohost_hit  = st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
    hang_hit    = (STALL_LIMIT != 0) && (idle_nxt == STALL_LIM_W);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (64'(cyc_nxt) == TIMEOUT_W);
    term        = tohost_hit || hang_hit || timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_HOLD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HOLD:  if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
      S_RUN:   if (term) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_HOLD;
    endcase
  end

  always_comb begin
    core_reset = 1'b1;
    running    = 1'b0;
    done       = 1'b0;
    case (state)
      S_RUN: begin
        core_reset = 1'b0;
        running    = 1'b1;
      end
      S_DONE: begin
        core_reset = HALT_ON_DONE;
        done       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
      idle_cnt <= '0;
      status_q <= ST_NONE;
      fail_q   <= '0;
    end else begin
      if (state == S_HOLD) hold_cnt <= hold_cnt + HOLD_W'(1);
      if (state == S_RUN) begin
        idle_cnt <= idle_nxt;
        if (tohost_hit) begin
          if (st_data == XLEN'(1)) status_q <= ST_PASS;
          else begin
            status_q <= ST_FAIL;
            fail_q   <= st_data >> 1;
          end
        end else if (hang_hit)    status_q <= ST_HANG;
        else if (timeout_hit)     status_q <= ST_TIMEOUT;
      end
    end
  end

  assign status    = status_q;
  assign fail_code = fail_q;
  assign cyc_inc   = (state == S_RUN) ? CNT_W'(1) : '0;
  assign ret_inc   = (state == S_RUN) ? ret_pop : '0;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state == S_HOLD),
    .inc   (cyc_inc),
    .q     (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state == S_HOLD),
    .inc   (ret_inc),
    .q     (instret_count)
  );

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl across four parameterisations sharing stimulus.
module tb_sim_run_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  rv = 2'b00;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // a: defaults, h: STALL_LIMIT=64, t: NUM_RET=2 TIMEOUT=500, s: CNT_W=4
  logic a_core_reset, a_running, a_done; logic [2:0] a_status; logic [31:0] a_fail, a_cyc, a_ret;
  logic h_core_reset, h_running, h_done; logic [2:0] h_status; logic [31:0] h_fail, h_cyc, h_ret;
  logic t_core_reset, t_running, t_done; logic [2:0] t_status; logic [31:0] t_fail, t_cyc, t_ret;
  logic s_core_reset, s_running, s_done; logic [2:0] s_status; logic [31:0] s_fail; logic [3:0] s_cyc, s_ret;

  sim_run_ctrl dut_a (
    .clk(clk), .reset(reset), .ret_valid(rv[0:0]), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .core_reset(a_core_reset), .running(a_running), .done(a_done),
    .status(a_status), .fail_code(a_fail), .cycle_count(a_cyc), .instret_count(a_ret));

  sim_run_ctrl #(.STALL_LIMIT(64)) dut_h (
    .clk(clk), .reset(reset), .ret_valid(rv[0:0]), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .core_reset(h_core_reset), .running(h_running), .done(h_done),
    .status(h_status), .fail_code(h_fail), .cycle_count(h_cyc), .instret_count(h_ret));

  sim_run_ctrl #(.NUM_RET(2), .TIMEOUT_CYCLES(500)) dut_t (
    .clk(clk), .reset(reset), .ret_valid(rv), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .core_reset(t_core_reset), .running(t_running), .done(t_done),
    .status(t_status), .fail_code(t_fail), .cycle_count(t_cyc), .instret_count(t_ret));

  sim_run_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .ret_valid(rv[0:0]), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .core_reset(s_core_reset), .running(s_running), .done(s_done),
    .status(s_status), .fail_code(s_fail), .cycle_count(s_cyc), .instret_count(s_ret));

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    st_valid = 1'b1;
    st_addr  = addr;
    st_data  = data;
    step(1);
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
  endtask

  // Leaves every instance at the first RUN cycle (after the 30 hold edges).
  task automatic do_reset();
    rv = 2'b00;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(30);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    step(3);
    total++; if ({a_core_reset, a_running, a_done, a_status, a_fail, a_cyc, a_ret} !== {3'b100, 3'd0, 96'd0})
      $display("FAIL reset_a got cr=%b run=%b done=%b st=%0d fc=%0h cyc=%0d ret=%0d want 1 0 0 0 0 0 0",
               a_core_reset, a_running, a_done, a_status, a_fail, a_cyc, a_ret); else passed++;
    total++; if ({h_core_reset, h_running, h_done, h_status, h_fail, h_cyc, h_ret} !== {3'b100, 3'd0, 96'd0})
      $display("FAIL reset_h got cr=%b run=%b done=%b st=%0d want 1 0 0 0", h_core_reset, h_running, h_done, h_status); else passed++;
    total++; if ({t_core_reset, t_running, t_done, t_status, t_fail, t_cyc, t_ret} !== {3'b100, 3'd0, 96'd0})
      $display("FAIL reset_t got cr=%b run=%b done=%b st=%0d want 1 0 0 0", t_core_reset, t_running, t_done, t_status); else passed++;
    total++; if ({s_core_reset, s_running, s_done, s_status, s_fail, s_cyc, s_ret} !== {3'b100, 3'd0, 40'd0})
      $display("FAIL reset_s got cr=%b run=%b done=%b st=%0d want 1 0 0 0", s_core_reset, s_running, s_done, s_status); else passed++;
    reset = 1'b0;
    n = 0;
    while (a_core_reset && n < 40) begin
      step(1);
      n++;
    end
    total++; if (n !== 30) $display("FAIL hold_edges got %0d want 30", n); else passed++;
    total++; if ({a_running, a_cyc, a_ret} !== {1'b1, 64'd0})
      $display("FAIL run_start got run=%b cyc=%0d ret=%0d want 1 0 0", a_running, a_cyc, a_ret); else passed++;
  endtask

  task automatic test_pass();
    do_reset();
    rv = 2'b01;
    step(99);
    total++; if (a_done !== 1'b0) $display("FAIL pass_early got done=%b want 0", a_done); else passed++;
    store(32'h1000, 32'h1);
    total++; if ({a_done, a_status, a_cyc, a_ret} !== {1'b1, 3'd1, 32'd100, 32'd100})
      $display("FAIL pass_verdict got done=%b st=%0d cyc=%0d ret=%0d want 1 1 100 100", a_done, a_status, a_cyc, a_ret); else passed++;
    total++; if ({a_core_reset, a_running} !== 2'b10)
      $display("FAIL pass_halt got cr=%b run=%b want 1 0", a_core_reset, a_running); else passed++;
  endtask

  task automatic test_fail();
    do_reset();
    rv = 2'b01;
    step(4);
    store(32'h1000, 32'h4);
    store(32'h2000, 32'h1);
    total++; if ({a_running, a_done, a_status} !== {2'b10, 3'd0})
      $display("FAIL ignored_stores got run=%b done=%b st=%0d want 1 0 0", a_running, a_done, a_status); else passed++;
    step(3);
    store(32'h1000, 32'hB);
    total++; if ({a_done, a_status, a_fail, a_cyc, a_ret} !== {1'b1, 3'd2, 32'd5, 32'd10, 32'd10})
      $display("FAIL fail_verdict got done=%b st=%0d fc=%0d cyc=%0d ret=%0d want 1 2 5 10 10",
               a_done, a_status, a_fail, a_cyc, a_ret); else passed++;
    store(32'h1000, 32'h7);
    step(5);
    total++; if ({a_done, a_status, a_fail, a_cyc, a_ret} !== {1'b1, 3'd2, 32'd5, 32'd10, 32'd10})
      $display("FAIL done_frozen got done=%b st=%0d fc=%0d cyc=%0d ret=%0d want 1 2 5 10 10",
               a_done, a_status, a_fail, a_cyc, a_ret); else passed++;
    reset = 1'b1;
    step(1);
    total++; if ({a_core_reset, a_running, a_done, a_status, a_fail, a_cyc, a_ret} !== {3'b100, 3'd0, 96'd0})
      $display("FAIL reset_in_done got cr=%b done=%b st=%0d fc=%0d cyc=%0d", a_core_reset, a_done, a_status, a_fail, a_cyc); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_hang();
    int n;
    do_reset();
    rv = 2'b00;
    n = 0;
    while (!h_done && n < 200) begin
      step(1);
      n++;
    end
    total++; if (n !== 64) $display("FAIL hang_edges got %0d want 64", n); else passed++;
    total++; if ({h_status, h_cyc, h_ret, h_core_reset} !== {3'd4, 32'd64, 32'd0, 1'b1})
      $display("FAIL hang_verdict got st=%0d cyc=%0d ret=%0d cr=%b want 4 64 0 1", h_status, h_cyc, h_ret, h_core_reset); else passed++;
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    rv = 2'b11;
    n = 0;
    while (!t_done && n < 700) begin
      step(1);
      n++;
    end
    total++; if (n !== 500) $display("FAIL timeout_edges got %0d want 500", n); else passed++;
    total++; if ({t_status, t_cyc, t_ret} !== {3'd3, 32'd500, 32'd1000})
      $display("FAIL timeout_verdict got st=%0d cyc=%0d ret=%0d want 3 500 1000", t_status, t_cyc, t_ret); else passed++;
  endtask

  task automatic test_tohost_vs_timeout();
    do_reset();
    rv = 2'b11;
    step(499);
    store(32'h1000, 32'h1);
    total++; if ({t_done, t_status, t_cyc, t_ret} !== {1'b1, 3'd1, 32'd500, 32'd1000})
      $display("FAIL tohost_priority got done=%b st=%0d cyc=%0d ret=%0d want 1 1 500 1000", t_done, t_status, t_cyc, t_ret); else passed++;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    rv = 2'b01;
    step(50);
    total++; if (a_cyc !== 32'd50) $display("FAIL mid_run_count got %0d want 50", a_cyc); else passed++;
    reset = 1'b1;
    step(1);
    total++; if ({a_core_reset, a_running, a_done, a_status, a_fail, a_cyc, a_ret} !== {3'b100, 3'd0, 96'd0})
      $display("FAIL reset_mid_run got cr=%b run=%b done=%b st=%0d cyc=%0d ret=%0d",
               a_core_reset, a_running, a_done, a_status, a_cyc, a_ret); else passed++;
    reset = 1'b0;
    step(1);
    total++; if ({a_core_reset, a_running} !== 2'b10)
      $display("FAIL rehold got cr=%b run=%b want 1 0", a_core_reset, a_running); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    rv = 2'b01;
    step(20);
    total++; if ({s_cyc, s_ret, s_running} !== {4'd15, 4'd15, 1'b1})
      $display("FAIL saturate got cyc=%0d ret=%0d run=%b want 15 15 1", s_cyc, s_ret, s_running); else passed++;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_hang();
    test_timeout();
    test_tohost_vs_timeout();
    test_reset_mid_run();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
